// File: rtl/inst_queue.sv
// Instruction queue between fetch and rename/dispatch: a circular FIFO of {inst, pc+4}
// entries with a separate occupancy count, flush-to-empty and a sticky overflow flag.
module inst_queue #(
  parameter int unsigned IQ_DEPTH    = 16,
  parameter int unsigned IQ_PTR_BITS = $clog2(IQ_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enqueue,
  input  logic [31:0]            inst_in,
  input  logic [31:0]            pc_in,
  input  logic                   dequeue,
  input  logic                   flush,
  output logic [31:0]            inst,
  output logic [31:0]            prog,
  output logic                   is_iqueue_empty,
  output logic                   is_iqueue_full,
  output logic [IQ_PTR_BITS:0]   iq_count,
  output logic                   iq_overflow
);

  localparam logic [IQ_PTR_BITS-1:0] PtrOne    = IQ_PTR_BITS'(1);
  localparam logic [IQ_PTR_BITS:0]   CountOne  = (IQ_PTR_BITS + 1)'(1);
  localparam logic [IQ_PTR_BITS:0]   CountFull = (IQ_PTR_BITS + 1)'(IQ_DEPTH);

  logic [31:0] inst_mem [IQ_DEPTH];
  logic [31:0] prog_mem [IQ_DEPTH];

  logic [IQ_PTR_BITS-1:0] head_q, head_d;
  logic [IQ_PTR_BITS-1:0] tail_q, tail_d;
  logic [IQ_PTR_BITS:0]   count_q, count_d;
  logic                   overflow_q, overflow_d;

  logic enq_acc;
  logic deq_acc;

  assign is_iqueue_empty = (count_q == '0);
  assign is_iqueue_full  = (count_q == CountFull);
  assign iq_count        = count_q;
  assign iq_overflow     = overflow_q;

  assign enq_acc = enqueue && !is_iqueue_full && !flush;
  assign deq_acc = dequeue && !is_iqueue_empty && !flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Overflow records the attempt itself, so it is independent of flush.
    if (enqueue && is_iqueue_full) begin
      overflow_d = 1'b1;
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_acc) begin
        tail_d = tail_q + PtrOne;
      end
      if (deq_acc) begin
        head_d = head_q + PtrOne;
      end
      unique case ({enq_acc, deq_acc})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (enq_acc) begin
      inst_mem[tail_q] <= inst_in;
      prog_mem[tail_q] <= pc_in + 32'd4;
    end
  end

  always_comb begin
    inst = 32'h0;
    prog = 32'h0;
    if (!is_iqueue_empty) begin
      inst = inst_mem[head_q];
      prog = prog_mem[head_q];
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue: fill/drain, wrap, simultaneous ops,
// overflow, flush and mid-operation reset.
module tb_inst_queue;

  logic        clk;
  logic        rst;
  logic        enqueue;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic        dequeue;
  logic        flush;
  logic [31:0] inst;
  logic [31:0] prog;
  logic        is_iqueue_empty;
  logic        is_iqueue_full;
  logic [4:0]  iq_count;
  logic        iq_overflow;

  int errors = 0;
  int checks = 0;

  inst_queue #(
    .IQ_DEPTH    (16),
    .IQ_PTR_BITS (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enqueue         (enqueue),
    .inst_in         (inst_in),
    .pc_in           (pc_in),
    .dequeue         (dequeue),
    .flush           (flush),
    .inst            (inst),
    .prog            (prog),
    .is_iqueue_empty (is_iqueue_empty),
    .is_iqueue_full  (is_iqueue_full),
    .iq_count        (iq_count),
    .iq_overflow     (iq_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs held; returns #1 after the edge with inputs idle.
  task automatic cyc(input logic r, input logic e, input logic [31:0] w, input logic [31:0] p,
                     input logic d, input logic f);
    rst = r; enqueue = e; inst_in = w; pc_in = p; dequeue = d; flush = f;
    @(posedge clk);
    #1;
    rst = 1'b0; enqueue = 1'b0; inst_in = '0; pc_in = '0; dequeue = 1'b0; flush = 1'b0;
  endtask

  task automatic enq(input logic [31:0] w, input logic [31:0] p);
    cyc(1'b0, 1'b1, w, p, 1'b0, 1'b0);
  endtask

  task automatic deq();
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(is_iqueue_empty), 32'd1);
    chk({tag, "_full"}, 32'(is_iqueue_full), 32'd0);
    chk({tag, "_count"}, 32'(iq_count), 32'd0);
    chk({tag, "_ovf"}, 32'(iq_overflow), 32'd0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_prog"}, prog, 32'h0);
  endtask

  initial begin
    rst = 1'b1; enqueue = 1'b0; inst_in = '0; pc_in = '0; dequeue = 1'b0; flush = 1'b0;
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk_reset_state("reset");

    // Fill and drain; first enqueue must not bypass to the head.
    enqueue = 1'b1; inst_in = 32'h13; pc_in = 32'h6000_0000;
    #1;
    chk("no_bypass_inst", inst, 32'h0);
    chk("no_bypass_empty", 32'(is_iqueue_empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      enq(32'h13 + 32'(i), 32'h6000_0000 + 32'(4 * i));
      if (i == 0) begin
        chk("first_visible", inst, 32'h13);
        chk("first_prog", prog, 32'h6000_0004);
      end
    end
    chk("fill_full", 32'(is_iqueue_full), 32'd1);
    chk("fill_count", 32'(iq_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_inst%0d", i), inst, 32'h13 + 32'(i));
      chk($sformatf("drain_prog%0d", i), prog, 32'h6000_0004 + 32'(4 * i));
      deq();
    end
    chk("drain_empty", 32'(is_iqueue_empty), 32'd1);
    chk("drain_inst0", inst, 32'h0);

    // Extra dequeue on empty queue is ignored.
    deq();
    chk("deq_empty_count", 32'(iq_count), 32'd0);

    // Wrap-around: 10 in/out, then 12 in -> tail wraps past 15.
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) enq(32'h100 + 32'(i), 32'h1000 + 32'(4 * i));
    for (int i = 0; i < 10; i++) deq();
    for (int i = 0; i < 12; i++) enq(32'h200 + 32'(i), 32'h2000 + 32'(4 * i));
    chk("wrap_count", 32'(iq_count), 32'd12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("wrap_inst%0d", i), inst, 32'h200 + 32'(i));
      chk($sformatf("wrap_prog%0d", i), prog, 32'h2004 + 32'(4 * i));
      deq();
    end
    chk("wrap_empty", 32'(is_iqueue_empty), 32'd1);

    // Simultaneous enqueue+dequeue at count 5.
    for (int i = 0; i < 5; i++) enq(32'h300 + 32'(i), 32'h3000 + 32'(4 * i));
    cyc(1'b0, 1'b1, 32'h3FF, 32'h3FFC, 1'b1, 1'b0);
    chk("simul_count", 32'(iq_count), 32'd5);
    chk("simul_head", inst, 32'h301);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("simul_inst%0d", i), inst, 32'h300 + 32'(i));
      deq();
    end
    chk("simul_new_inst", inst, 32'h3FF);
    chk("simul_new_prog", prog, 32'h4000);
    deq();
    chk("simul_empty", 32'(is_iqueue_empty), 32'd1);

    // Full with enqueue+dequeue: enqueue dropped, overflow sticky across flush.
    for (int i = 0; i < 16; i++) enq(32'h400 + 32'(i), 32'h4000 + 32'(4 * i));
    chk("ovf_pre", 32'(iq_overflow), 32'd0);
    cyc(1'b0, 1'b1, 32'hBAD, 32'hBAD0, 1'b1, 1'b0);
    chk("ovf_count", 32'(iq_count), 32'd15);
    chk("ovf_flag", 32'(iq_overflow), 32'd1);
    chk("ovf_head", inst, 32'h401);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("ovf_flush_count", 32'(iq_count), 32'd0);
    chk("ovf_sticky", 32'(iq_overflow), 32'd1);

    // Flush with 7 entries plus enqueue and dequeue.
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("ovf_cleared_by_rst", 32'(iq_overflow), 32'd0);
    for (int i = 0; i < 7; i++) enq(32'h500 + 32'(i), 32'h5000 + 32'(4 * i));
    chk("fl_pre_count", 32'(iq_count), 32'd7);
    cyc(1'b0, 1'b1, 32'h5FF, 32'h5FFC, 1'b1, 1'b1);
    chk("fl_count", 32'(iq_count), 32'd0);
    chk("fl_empty", 32'(is_iqueue_empty), 32'd1);
    chk("fl_inst", inst, 32'h0);
    enqueue = 1'b1; inst_in = 32'h777; pc_in = 32'h7000;
    #1;
    chk("fl_no_bypass", inst, 32'h0);
    enq(32'h777, 32'h7000);
    chk("fl_after_inst", inst, 32'h777);
    chk("fl_after_prog", prog, 32'h7004);
    chk("fl_after_count", 32'(iq_count), 32'd1);

    // Mid-operation reset at count 9 with enqueue asserted.
    for (int i = 0; i < 8; i++) enq(32'h600 + 32'(i), 32'h6000 + 32'(4 * i));
    chk("mr_pre_count", 32'(iq_count), 32'd9);
    cyc(1'b1, 1'b1, 32'h6FF, 32'h6FFC, 1'b1, 1'b1);
    chk_reset_state("midrst");
    deq();
    chk_reset_state("midrst_deq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter IQ_DEPTH, default 16, SHALL set the entry count; legal values are powers of two, 4..64.
REQ-002 Parameter IQ_PTR_BITS, default $clog2(IQ_DEPTH), SHALL set the head/tail pointer width.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 enqueue  in  1  fetch offers an instruction this cycle.
REQ-006 inst_in  in  32  fetched instruction word.
REQ-007 pc_in  in  32  address of inst_in.
REQ-008 dequeue  in  1  rename/dispatch consumes the head entry this cycle.
REQ-009 flush  in  1  branch redirect; discard all entries.
REQ-010 inst  out  32  instruction word of the head entry.
REQ-011 prog  out  32  head entry pc_in + 4; dispatch uses prog - 4 as the instruction PC.
REQ-012 is_iqueue_empty  out  1  queue holds zero entries.
REQ-013 is_iqueue_full  out  1  queue holds IQ_DEPTH entries.
REQ-014 iq_count  out  IQ_PTR_BITS+1  current occupancy, 0..IQ_DEPTH.
REQ-015 iq_overflow  out  1  sticky error: enqueue was attempted while full.

Function
REQ-016 Storage SHALL be a circular buffer of IQ_DEPTH {inst, pc+4} entries, with head, tail and a separate count register.
REQ-017 Entries SHALL leave in strict FIFO order.
REQ-018 inst and prog SHALL be driven combinationally from the head entry with zero-cycle latency.
REQ-019 When is_iqueue_empty = 1, inst and prog SHALL both be 32'h0.
REQ-020 An accepted enqueue SHALL write the entry at tail and increment tail modulo IQ_DEPTH.
REQ-021 An accepted dequeue SHALL increment head modulo IQ_DEPTH.
REQ-022 Pointers SHALL wrap from IQ_DEPTH-1 to 0 with no lost or duplicated entry.
REQ-023 An enqueue is accepted iff enqueue = 1, is_iqueue_full = 0 and flush = 0.
REQ-024 An enqueue while full SHALL be dropped, even if dequeue = 1 in the same cycle.
REQ-025 An enqueue while full SHALL set iq_overflow.
REQ-026 A dequeue is accepted iff dequeue = 1, is_iqueue_empty = 0 and flush = 0.
REQ-027 A dequeue while empty SHALL be ignored with no state change.
REQ-028 Accepted enqueue and dequeue in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-029 An enqueue into an empty queue SHALL NOT be visible at the head until the next cycle; there is no bypass.
REQ-030 flush has highest priority: head, tail and count SHALL become 0 next cycle.
REQ-031 Same-cycle enqueue and dequeue SHALL be discarded when flush = 1.
REQ-032 iq_overflow SHALL NOT be cleared by flush.
REQ-033 is_iqueue_empty, is_iqueue_full and iq_count SHALL be decoded from the count register.
REQ-034 The consumer registers the empty flag, so the queue SHALL tolerate a dequeue asserted one cycle after it emptied; REQ-027 covers this.

Reset
REQ-035 While rst = 1: head = tail = count = 0, is_iqueue_empty = 1, is_iqueue_full = 0, iq_count = 0, iq_overflow = 0, inst = prog = 0.
REQ-036 rst SHALL override flush, enqueue and dequeue in the same cycle.
REQ-037 Storage contents need not be reset.

Verification
REQ-038 Fill and drain: reset, then enqueue 16 words 0x00000013+i with pc 0x60000000+4i -> full = 1 and count = 16 after cycle 16; 16 dequeues return them in order with prog = 0x60000004+4i; empty = 1 at the end.
REQ-039 Wrap-around: 10 enqueues and 10 dequeues, then 12 enqueues -> tail wraps to 6; the head is entry 10; data order is intact.
REQ-040 Simultaneous enqueue+dequeue at count = 5 -> count stays 5; the head advances; the new entry lands at tail.
REQ-041 Full with enqueue+dequeue -> the enqueue is dropped; count = 15; iq_overflow = 1 and stays 1 after a flush.
REQ-042 Flush with 7 entries plus enqueue and dequeue asserted -> next cycle count = 0, empty = 1, inst = 0; the following enqueue appears at the head a cycle later.
REQ-043 Mid-operation reset: rst at count = 9 with enqueue = 1 -> next cycle all outputs at the REQ-035 values; a dequeue on an empty queue changes nothing.
